// File: rtl/image_scaler_pkg.sv
// Shared encodings, FSM states and elaboration helpers for the 2x image scaler.
package image_scaler_pkg;

    typedef enum logic [1:0] {
        ALG_REPLICATE = 2'd0,
        ALG_DECIMATE  = 2'd1,
        ALG_AVERAGE   = 2'd2,
        ALG_RSVD      = 2'd3
    } alg_t;

    // ACC names the accumulate-and-decide step of averaging; that decision is
    // made on the last WT edge so the step never costs a cycle of its own.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WT,
        ST_ACC,
        ST_WR,
        ST_FIN
    } state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic bit rd_lat_in_range(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/scaler_addr_gen.sv
// Frame walk counters and per-mode read/write address mapping for image_scaler.
// The read address is mapped from the counters' next values so the parent can
// register it on the same edge that steps the counters.
module scaler_addr_gen
    import image_scaler_pkg::*;
#(
    parameter int SRC_W = 160,
    parameter int SRC_H = 120,
    parameter int RA_W  = clog2(SRC_W * SRC_H),
    parameter int WA_W  = clog2(4 * SRC_W * SRC_H)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  alg_t            mode,
    input  logic            clear,
    input  logic            sub_step,
    input  logic            pix_step,
    output logic            sub_last,
    output logic            frame_last,
    output logic [RA_W-1:0] rd_addr,
    output logic [WA_W-1:0] wr_addr
);

    localparam int XW = clog2(SRC_W);
    localparam int YW = clog2(SRC_H);
    localparam logic [XW-1:0] X_LAST_FULL = XW'(SRC_W - 1);
    localparam logic [XW-1:0] X_LAST_HALF = XW'(SRC_W / 2 - 1);
    localparam logic [YW-1:0] Y_LAST_FULL = YW'(SRC_H - 1);
    localparam logic [YW-1:0] Y_LAST_HALF = YW'(SRC_H / 2 - 1);

    logic [XW-1:0] x, x_next, x_last;
    logic [YW-1:0] y, y_next, y_last;
    logic          dx, dy, dx_next, dy_next;
    logic [31:0]   rd_full, wr_full;

    // Replicate walks every source pixel; the /2 modes walk the half-size output grid
    always_comb begin
        x_last = (mode == ALG_REPLICATE) ? X_LAST_FULL : X_LAST_HALF;
        y_last = (mode == ALG_REPLICATE) ? Y_LAST_FULL : Y_LAST_HALF;
    end

    assign sub_last   = dx & dy;
    assign frame_last = (x == x_last) && (y == y_last);

    // Sub index runs (0,0),(1,0),(0,1),(1,1); the pixel position holds at frame end
    always_comb begin
        x_next  = x;
        y_next  = y;
        dx_next = dx;
        dy_next = dy;
        if (clear) begin
            x_next  = '0;
            y_next  = '0;
            dx_next = 1'b0;
            dy_next = 1'b0;
        end else begin
            if (sub_step) begin
                dx_next = ~dx;
                if (dx) begin
                    dy_next = ~dy;
                end
            end
            if (pix_step && !frame_last) begin
                if (x == x_last) begin
                    x_next = '0;
                    y_next = y + YW'(1);
                end else begin
                    x_next = x + XW'(1);
                end
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x  <= '0;
            y  <= '0;
            dx <= 1'b0;
            dy <= 1'b0;
        end else begin
            x  <= x_next;
            y  <= y_next;
            dx <= dx_next;
            dy <= dy_next;
        end
    end

    // Map counters to source and destination addresses for the running mode
    always_comb begin
        if (mode == ALG_REPLICATE) begin
            rd_full = 32'(y_next) * SRC_W + 32'(x_next);
            wr_full = (32'(y) * 2 + 32'(dy)) * (2 * SRC_W) + 32'(x) * 2 + 32'(dx);
        end else begin
            rd_full = (32'(y_next) * 2 + 32'(dy_next)) * SRC_W + 32'(x_next) * 2 + 32'(dx_next);
            wr_full = 32'(y) * (SRC_W / 2) + 32'(x);
        end
        rd_addr = RA_W'(rd_full);
        wr_addr = WA_W'(wr_full);
    end

endmodule

// File: rtl/image_scaler.sv
// 2x image scaling engine: replicate, decimate or 2x2-average one source frame
// from a synchronous-read RAM into a destination write port.
module image_scaler
    import image_scaler_pkg::*;
#(
    parameter int SRC_W  = 160,
    parameter int SRC_H  = 120,
    parameter int PIX_W  = 8,
    parameter int RD_LAT = 1,
    parameter int RA_W   = clog2(SRC_W * SRC_H),
    parameter int WA_W   = clog2(4 * SRC_W * SRC_H)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [1:0]       ALGORITHM,
    input  logic [PIX_W-1:0] PIXEL_IN,
    output logic [RA_W-1:0]  R_ADDR,
    output logic [PIX_W-1:0] PIXEL_OUT,
    output logic [WA_W-1:0]  W_ADDR,
    output logic             W_EN,
    output logic             BUSY,
    output logic             done,
    output logic             ERROR
);

    if ((SRC_W % 2) != 0) begin : g_bad_src_w
        $error("image_scaler: SRC_W must be even");
    end
    if ((SRC_H % 2) != 0) begin : g_bad_src_h
        $error("image_scaler: SRC_H must be even");
    end
    if (!rd_lat_in_range(RD_LAT)) begin : g_bad_rd_lat
        $error("image_scaler: RD_LAT must be within 1..3");
    end

    state_t           state;
    alg_t             alg;
    logic [1:0]       wait_cnt;
    logic             wt_last;
    logic [PIX_W+1:0] acc, acc_rounded;
    logic [PIX_W-1:0] hold_pix;

    logic             ag_clear, ag_sub_step, ag_pix_step;
    logic             ag_sub_last, ag_frame_last;
    logic [RA_W-1:0]  ag_rd_addr;
    logic [WA_W-1:0]  ag_wr_addr;

    assign wt_last     = (wait_cnt == 2'(RD_LAT - 1));
    assign acc_rounded = acc + (PIX_W + 2)'(2);

    scaler_addr_gen #(
        .SRC_W (SRC_W),
        .SRC_H (SRC_H),
        .RA_W  (RA_W),
        .WA_W  (WA_W)
    ) u_addr_gen (
        .clk        (CLK),
        .rst_n      (RESET),
        .mode       (alg),
        .clear      (ag_clear),
        .sub_step   (ag_sub_step),
        .pix_step   (ag_pix_step),
        .sub_last   (ag_sub_last),
        .frame_last (ag_frame_last),
        .rd_addr    (ag_rd_addr),
        .wr_addr    (ag_wr_addr)
    );

    // Counter control: averaging steps its sub index per read, replicate per write
    always_comb begin
        ag_clear    = (state == ST_IDLE) && START;
        ag_sub_step = 1'b0;
        ag_pix_step = 1'b0;
        case (state)
            ST_WT: begin
                if (wt_last && (alg == ALG_AVERAGE)) begin
                    ag_sub_step = 1'b1;
                end
            end
            ST_WR: begin
                if (alg == ALG_REPLICATE) begin
                    ag_sub_step = 1'b1;
                    ag_pix_step = ag_sub_last;
                end else begin
                    ag_pix_step = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Frame FSM with registered outputs; outputs reflect the state of the previous cycle
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state     <= ST_IDLE;
            alg       <= ALG_REPLICATE;
            wait_cnt  <= '0;
            acc       <= '0;
            hold_pix  <= '0;
            R_ADDR    <= '0;
            PIXEL_OUT <= '0;
            W_ADDR    <= '0;
            W_EN      <= 1'b0;
            BUSY      <= 1'b0;
            done      <= 1'b0;
            ERROR     <= 1'b0;
        end else begin
            W_EN  <= 1'b0;
            done  <= 1'b0;
            ERROR <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        alg  <= alg_t'(ALGORITHM);
                        acc  <= '0;
                        BUSY <= 1'b1;
                        if (ALGORITHM == ALG_RSVD) begin
                            state <= ST_FIN;
                        end else begin
                            state  <= ST_RD;
                            R_ADDR <= ag_rd_addr;
                        end
                    end
                end
                ST_RD: begin
                    wait_cnt <= '0;
                    state    <= ST_WT;
                end
                ST_WT: begin
                    if (wt_last) begin
                        if (alg == ALG_AVERAGE) begin
                            acc <= acc + {2'b00, PIXEL_IN};
                            if (ag_sub_last) begin
                                state <= ST_WR;
                            end else begin
                                state  <= ST_RD;
                                R_ADDR <= ag_rd_addr;
                            end
                        end else begin
                            hold_pix <= PIXEL_IN;
                            state    <= ST_WR;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                ST_WR: begin
                    W_EN      <= 1'b1;
                    W_ADDR    <= ag_wr_addr;
                    PIXEL_OUT <= (alg == ALG_AVERAGE) ? acc_rounded[PIX_W+1:2] : hold_pix;
                    acc       <= '0;
                    if ((alg != ALG_REPLICATE) || ag_sub_last) begin
                        if (ag_frame_last) begin
                            state <= ST_FIN;
                        end else begin
                            state  <= ST_RD;
                            R_ADDR <= ag_rd_addr;
                        end
                    end
                end
                ST_FIN: begin
                    done  <= 1'b1;
                    ERROR <= (alg == ALG_RSVD);
                    BUSY  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_scaler.sv
// Randomized self-checking bench for image_scaler on a 4x4 frame, with one
// instance at RD_LAT=1 and one at RD_LAT=2 sharing the same source RAM contents.
module tb_image_scaler;

    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;

    logic       start0, start1;
    logic [1:0] alg0, alg1;
    logic [7:0] pixel_in0, pixel_in1, pixel_out0, pixel_out1;
    logic [3:0] r_addr0, r_addr1;
    logic [5:0] w_addr0, w_addr1;
    logic       w_en0, w_en1, busy0, busy1, done0, done1, error0, error1;

    image_scaler #(.SRC_W(W), .SRC_H(H), .PIX_W(8), .RD_LAT(1)) dut0 (
        .CLK(clk), .RESET(rst_n), .START(start0), .ALGORITHM(alg0), .PIXEL_IN(pixel_in0),
        .R_ADDR(r_addr0), .PIXEL_OUT(pixel_out0), .W_ADDR(w_addr0), .W_EN(w_en0),
        .BUSY(busy0), .done(done0), .ERROR(error0)
    );

    image_scaler #(.SRC_W(W), .SRC_H(H), .PIX_W(8), .RD_LAT(2)) dut1 (
        .CLK(clk), .RESET(rst_n), .START(start1), .ALGORITHM(alg1), .PIXEL_IN(pixel_in1),
        .R_ADDR(r_addr1), .PIXEL_OUT(pixel_out1), .W_ADDR(w_addr1), .W_EN(w_en1),
        .BUSY(busy1), .done(done1), .ERROR(error1)
    );

    // Source RAM model with per-instance read pipelines
    logic [7:0] src_mem [N];
    logic [7:0] pipe0, pipe1a, pipe1b;
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        pipe0  <= src_mem[r_addr0];
        pipe1a <= src_mem[r_addr1];
        pipe1b <= pipe1a;
    end
    assign pixel_in0 = pipe0;
    assign pixel_in1 = pipe1b;

    // Observation mux for whichever instance is under test
    int         sel;
    logic       m_w_en, m_busy, m_done, m_error;
    logic [3:0] m_r_addr;
    logic [5:0] m_w_addr;
    logic [7:0] m_pixel_out;
    assign m_w_en      = (sel == 1) ? w_en1      : w_en0;
    assign m_busy      = (sel == 1) ? busy1      : busy0;
    assign m_done      = (sel == 1) ? done1      : done0;
    assign m_error     = (sel == 1) ? error1     : error0;
    assign m_r_addr    = (sel == 1) ? r_addr1    : r_addr0;
    assign m_w_addr    = (sel == 1) ? w_addr1    : w_addr0;
    assign m_pixel_out = (sel == 1) ? pixel_out1 : pixel_out0;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [5:0] exp_addr [$];
    logic [7:0] exp_data [$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int dut, input logic st, input logic [1:0] alg);
        if (dut == 1) begin
            start1 = st;
            alg1   = alg;
        end else begin
            start0 = st;
            alg0   = alg;
        end
    endtask

    // Reference output stream computed directly from the scaling rules
    task automatic build_expected(input logic [1:0] alg);
        int sum;
        exp_addr.delete();
        exp_data.delete();
        if (alg == 2'd0) begin
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    for (int k = 0; k < 4; k++) begin
                        exp_addr.push_back(6'((2 * y + k / 2) * 2 * W + 2 * x + k % 2));
                        exp_data.push_back(src_mem[y * W + x]);
                    end
        end else if (alg == 2'd1) begin
            for (int y = 0; y < H / 2; y++)
                for (int x = 0; x < W / 2; x++) begin
                    exp_addr.push_back(6'(y * (W / 2) + x));
                    exp_data.push_back(src_mem[2 * y * W + 2 * x]);
                end
        end else if (alg == 2'd2) begin
            for (int y = 0; y < H / 2; y++)
                for (int x = 0; x < W / 2; x++) begin
                    sum = int'(src_mem[2 * y * W + 2 * x]) + int'(src_mem[2 * y * W + 2 * x + 1])
                        + int'(src_mem[(2 * y + 1) * W + 2 * x]) + int'(src_mem[(2 * y + 1) * W + 2 * x + 1]);
                    exp_addr.push_back(6'(y * (W / 2) + x));
                    exp_data.push_back(8'((sum + 2) / 4));
                end
        end
    endtask

    function automatic int expected_latency(input logic [1:0] alg, input int lat);
        case (alg)
            2'd0:    return N * (5 + lat) + 1;
            2'd1:    return (N / 4) * (2 + lat) + 1;
            2'd2:    return (N / 4) * (4 * (1 + lat) + 1) + 1;
            default: return 1;
        endcase
    endfunction

    task automatic randomize_src();
        for (int a = 0; a < N; a++) src_mem[a] = 8'($urandom_range(255, 0));
    endtask

    // One frame: start, follow writes against the model, optionally reset or re-pulse START mid-frame
    task automatic run_frame(input int dut, input logic [1:0] alg, input int reset_after, input int start_after);
        int         n, start_edge, done_edge, pulse_c, events;
        logic       got_done;
        logic [3:0] r_before;
        sel = dut;
        build_expected(alg);
        @(negedge clk);
        r_before = m_r_addr;
        applyStimulus(dut, 1'b1, alg);
        start_edge = cyc + 1;
        n = 0;
        got_done = 1'b0;
        done_edge = 0;
        pulse_c = -1;
        for (int c = 0; c < 1000 && !got_done; c++) begin
            @(negedge clk);
            if (c == 0 || c == pulse_c) applyStimulus(dut, 1'b0, 2'($urandom_range(3, 0)));
            if (c == 0) checkOutput("busy_after_start", 32'(m_busy), 1);
            if (m_w_en) begin
                if (n < exp_addr.size()) begin
                    checkOutput($sformatf("w_addr[%0d]", n), 32'(m_w_addr), 32'(exp_addr[n]));
                    checkOutput($sformatf("pixel_out[%0d]", n), 32'(m_pixel_out), 32'(exp_data[n]));
                end
                n++;
                if (n == start_after) begin
                    applyStimulus(dut, 1'b1, 2'd1);
                    pulse_c = c + 1;
                end
                if (n == reset_after) begin
                    rst_n = 1'b0;
                    @(negedge clk);
                    rst_n = 1'b1;
                    checkOutput("w_en_after_reset", 32'(m_w_en), 0);
                    checkOutput("busy_after_reset", 32'(m_busy), 0);
                    checkOutput("done_after_reset", 32'(m_done), 0);
                    checkOutput("error_after_reset", 32'(m_error), 0);
                    checkOutput("r_addr_after_reset", 32'(m_r_addr), 0);
                    checkOutput("w_addr_after_reset", 32'(m_w_addr), 0);
                    checkOutput("pixel_out_after_reset", 32'(m_pixel_out), 0);
                    events = 0;
                    repeat (200) begin
                        @(negedge clk);
                        if (m_w_en || m_done) events++;
                    end
                    checkOutput("activity_after_reset", 32'(events), 0);
                    return;
                end
            end
            if (m_done) begin
                got_done = 1'b1;
                done_edge = cyc;
                checkOutput("busy_at_done", 32'(m_busy), 0);
                checkOutput("error_at_done", 32'(m_error), 32'(alg == 2'd3));
            end
        end
        checkOutput("done_seen", 32'(got_done), 1);
        checkOutput("write_count", 32'(n), 32'(exp_addr.size()));
        if (got_done) begin
            checkOutput("done_latency", 32'(done_edge - start_edge), 32'(expected_latency(alg, dut + 1)));
            @(negedge clk);
            checkOutput("done_one_cycle", 32'(m_done), 0);
            checkOutput("error_one_cycle", 32'(m_error), 0);
        end
        if (alg == 2'd3) checkOutput("r_addr_held", 32'(m_r_addr), 32'(r_before));
    endtask

    initial begin
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        alg0   = 2'd0;
        alg1   = 2'd0;
        sel    = 0;
        for (int a = 0; a < N; a++) src_mem[a] = 8'(a);
        repeat (3) @(negedge clk);
        checkOutput("reset_w_en", 32'(w_en0), 0);
        checkOutput("reset_busy", 32'(busy0), 0);
        checkOutput("reset_done", 32'(done0), 0);
        checkOutput("reset_error", 32'(error0), 0);
        checkOutput("reset_r_addr", 32'(r_addr0), 0);
        checkOutput("reset_w_addr", 32'(w_addr0), 0);
        checkOutput("reset_pixel_out", 32'(pixel_out0), 0);
        checkOutput("reset_busy_lat2", 32'(busy1), 0);
        rst_n = 1'b1;

        $display("[TB] replicate, identity source");
        run_frame(0, 2'd0, -1, -1);
        $display("[TB] decimate, identity source");
        run_frame(0, 2'd1, -1, -1);

        $display("[TB] average with boundary blocks");
        randomize_src();
        src_mem[0]  = 8'd10;  src_mem[1]  = 8'd11;  src_mem[4]  = 8'd12;  src_mem[5]  = 8'd13;
        src_mem[10] = 8'd255; src_mem[11] = 8'd255; src_mem[14] = 8'd255; src_mem[15] = 8'd254;
        run_frame(0, 2'd2, -1, -1);

        $display("[TB] reserved algorithm");
        run_frame(0, 2'd3, -1, -1);

        $display("[TB] reset after 10th replicate write, then full frame");
        randomize_src();
        run_frame(0, 2'd0, 10, -1);
        run_frame(0, 2'd0, -1, -1);

        $display("[TB] START pulsed mid-replicate");
        run_frame(0, 2'd0, -1, 20);

        $display("[TB] replicate at RD_LAT=2");
        randomize_src();
        run_frame(1, 2'd0, -1, -1);

        $display("[TB] random frames");
        for (int k = 0; k < 6; k++) begin
            randomize_src();
            run_frame(int'($urandom_range(1, 0)), 2'($urandom_range(2, 0)), -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
